// File: rtl/sched_pkg.sv
// Shared types and constants for the task scheduler core.
//
// Contents:
//   cmd_op_e        command opcodes carried on cmd_op
//   sched_state_e   scheduler FSM states
//   Def*            default widths and sizes used by the core's parameters
package sched_pkg;

  typedef enum logic [1:0] {
    OpSetReady = 2'd0,
    OpClrReady = 2'd1,
    OpDelay    = 2'd2,
    OpSetPrio  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEval    = 2'd1,
    StReq     = 2'd2,
    StWaitAck = 2'd3
  } sched_state_e;

  localparam int unsigned DefNumTasks = 8;
  localparam int unsigned DefPrioW    = 3;
  localparam int unsigned DefDlyW     = 16;
  localparam int unsigned DefTickDiv  = 1000;

endpackage

// File: rtl/sched_prio_select.sv
// Combinational winner selection: picks the highest-priority ready task.
//
// Ties:
//   default                 lowest index wins
//   SCHED_ROUND_ROBIN_EN    first tied task above cur_id_i wins, wrapping
//
// Ports:
//   ready_i   per-task ready bits
//   prio_i    per-task priorities (higher is more urgent)
//   cur_id_i  currently running task (rotation origin)
//   winner_o  selected task index
module sched_prio_select #(
  parameter int unsigned NUM_TASKS = 8,
  parameter int unsigned PRIO_W    = 3,
  parameter int unsigned ID_W      = $clog2(NUM_TASKS)
) (
  input  logic [NUM_TASKS-1:0]             ready_i,
  input  logic [NUM_TASKS-1:0][PRIO_W-1:0] prio_i,
  input  logic [ID_W-1:0]                  cur_id_i,
  output logic [ID_W-1:0]                  winner_o
);

  int unsigned       start;
  logic [PRIO_W-1:0] best_prio;
  logic              found;
  logic [ID_W-1:0]   idx;

`ifdef SCHED_ROUND_ROBIN_EN
  assign start = 32'(cur_id_i) + 32'd1;
`else
  logic unused_cur_id;
  assign unused_cur_id = ^cur_id_i;
  assign start         = 32'd0;
`endif

  // Scan in rotation order from 'start'; a strict '>' keeps the first task
  // seen at the best priority, which yields the tie-break rule.
  always_comb begin
    best_prio = '0;
    found     = 1'b0;
    winner_o  = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_TASKS; off++) begin
      idx = ID_W'((start + off) % NUM_TASKS);
      if (ready_i[idx] && (!found || (prio_i[idx] > best_prio))) begin
        found     = 1'b1;
        best_prio = prio_i[idx];
        winner_o  = idx;
      end
    end
  end

endmodule

// File: rtl/task_sched_core.sv
// Task scheduler core: ready set, per-task delay counters and priorities,
// periodic tick, and a context-switch request/acknowledge FSM.
//
// Optional feature macro: SCHED_ROUND_ROBIN_EN
//   Tied priorities rotate after cur_id, and every tick re-evaluates the
//   winner so equal-priority tasks are time-sliced.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready low only while evaluating)
//   cmd_op/cmd_id/cmd_arg  opcode, target task, delay ticks or priority
//   sw_req/sw_ack/next_id  context-switch request, ack and proposed task
//   cur_id                 running task
//   ready_mask             ready set (bit 0 always set)
//   tick                   one-cycle pulse every TICK_DIV cycles
module task_sched_core
  import sched_pkg::*;
#(
  parameter int unsigned NUM_TASKS = DefNumTasks,
  parameter int unsigned PRIO_W    = DefPrioW,
  parameter int unsigned DLY_W     = DefDlyW,
  parameter int unsigned TICK_DIV  = DefTickDiv
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(NUM_TASKS)-1:0] cmd_id,
  input  logic [DLY_W-1:0]             cmd_arg,
  output logic                         sw_req,
  input  logic                         sw_ack,
  output logic [$clog2(NUM_TASKS)-1:0] next_id,
  output logic [$clog2(NUM_TASKS)-1:0] cur_id,
  output logic [NUM_TASKS-1:0]         ready_mask,
  output logic                         tick
);

  localparam int unsigned ID_W  = $clog2(NUM_TASKS);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]                 tick_cnt_q, tick_cnt_d;
  logic                             tick_q, tick_d;
  logic [NUM_TASKS-1:0][DLY_W-1:0]  delay_q, delay_d;
  logic [NUM_TASKS-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_TASKS-1:0]             ready_q, ready_d;
  logic                             dirty_q, dirty_d;
  sched_state_e                     state_q, state_d;
  logic [ID_W-1:0]                  cur_id_q, cur_id_d;
  logic [ID_W-1:0]                  next_id_q, next_id_d;
  logic                             sw_req_q, sw_req_d;

  logic            cmd_fire;
  logic            expire_any;
  logic            sched_event;
  logic [ID_W-1:0] winner;

  assign cmd_ready = (state_q != StEval);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Tick divider
  always_comb begin
    tick_cnt_d = tick_cnt_q + CNT_W'(1);
    tick_d     = 1'b0;
    if (tick_cnt_q == CNT_W'(TICK_DIV - 1)) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end
  end

  // Per-task state. The tick effect is applied first so that a command to
  // the same task in the same cycle overrides it.
  always_comb begin
    delay_d    = delay_q;
    prio_d     = prio_q;
    ready_d    = ready_q;
    expire_any = 1'b0;
    for (int unsigned i = 0; i < NUM_TASKS; i++) begin
      if (tick_q && (delay_q[i] != '0)) begin
        delay_d[i] = delay_q[i] - DLY_W'(1);
        if (delay_q[i] == DLY_W'(1)) begin
          ready_d[i] = 1'b1;
          expire_any = 1'b1;
        end
      end
      if (cmd_fire && (cmd_id == ID_W'(i))) begin
        unique case (cmd_op_e'(cmd_op))
          OpSetReady: begin
            ready_d[i] = 1'b1;
            delay_d[i] = '0;
          end
          OpClrReady: ready_d[i] = 1'b0;
          OpDelay: begin
            if (cmd_arg == '0) begin
              ready_d[i] = 1'b1;
              delay_d[i] = '0;
            end else begin
              ready_d[i] = 1'b0;
              delay_d[i] = cmd_arg;
            end
          end
          OpSetPrio: prio_d[i] = cmd_arg[PRIO_W-1:0];
          default: ;
        endcase
      end
    end
    // The idle task is always runnable and never delayed.
    ready_d[0] = 1'b1;
    delay_d[0] = '0;
  end

  // Without time-slicing a tick only matters when it wakes a task.
`ifdef SCHED_ROUND_ROBIN_EN
  assign sched_event = cmd_fire || tick_q || expire_any;
`else
  assign sched_event = cmd_fire || expire_any;
`endif

  sched_prio_select #(
    .NUM_TASKS (NUM_TASKS),
    .PRIO_W    (PRIO_W),
    .ID_W      (ID_W)
  ) u_prio_select (
    .ready_i  (ready_q),
    .prio_i   (prio_q),
    .cur_id_i (cur_id_q),
    .winner_o (winner)
  );

  // Switch FSM
  always_comb begin
    state_d   = state_q;
    dirty_d   = dirty_q;
    cur_id_d  = cur_id_q;
    next_id_d = next_id_q;
    sw_req_d  = sw_req_q;
    unique case (state_q)
      StIdle: begin
        if (dirty_q) state_d = StEval;
      end
      StEval: begin
        dirty_d   = 1'b0;
        next_id_d = winner;
        if (winner != cur_id_q) begin
          state_d  = StReq;
          sw_req_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StReq: begin
        // sw_ack is not honoured until WAIT_ACK.
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (sw_ack) begin
          cur_id_d = next_id_q;
          sw_req_d = 1'b0;
          state_d  = dirty_q ? StEval : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // An event arriving while EVAL consumes the flag must not be lost.
    if (sched_event) dirty_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      delay_q    <= '0;
      prio_q     <= '0;
      ready_q    <= NUM_TASKS'(1);
      dirty_q    <= 1'b0;
      state_q    <= StIdle;
      cur_id_q   <= '0;
      next_id_q  <= '0;
      sw_req_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      delay_q    <= delay_d;
      prio_q     <= prio_d;
      ready_q    <= ready_d;
      dirty_q    <= dirty_d;
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      next_id_q  <= next_id_d;
      sw_req_q   <= sw_req_d;
    end
  end

  assign sw_req     = sw_req_q;
  assign next_id    = next_id_q;
  assign cur_id     = cur_id_q;
  assign ready_mask = ready_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_task_sched_core.sv
// Self-checking bench for task_sched_core (8 tasks, TICK_DIV = 4).
module tb_task_sched_core;

  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_id;
  logic [15:0] cmd_arg;
  logic        sw_req;
  logic        sw_ack;
  logic [2:0]  next_id;
  logic [2:0]  cur_id;
  logic [7:0]  ready_mask;
  logic        tick;

  int n_cmp = 0;
  int n_err = 0;
  int tick_seen = 0;

  // Reference model: ready set, priorities and running task
  bit m_ready[8];
  int m_prio[8];
  int m_cur;

  task_sched_core #(
    .NUM_TASKS (8),
    .PRIO_W    (3),
    .DLY_W     (16),
    .TICK_DIV  (4)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_id     (cmd_id),
    .cmd_arg    (cmd_arg),
    .sw_req     (sw_req),
    .sw_ack     (sw_ack),
    .next_id    (next_id),
    .cur_id     (cur_id),
    .ready_mask (ready_mask),
    .tick       (tick)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_ready[k] = (k == 0);
      m_prio[k]  = 0;
    end
    m_cur = 0;
  endfunction

  // Delays used with the model never expire, so only their ready effect matters.
  function automatic void model_apply(input int op, input int id, input int arg);
    if (op == 3) m_prio[id] = arg % 8;
    else if (id != 0) begin
      if (op == 0) m_ready[id] = 1'b1;
      else if (op == 1) m_ready[id] = 1'b0;
      else m_ready[id] = (arg == 0);
    end
  endfunction

  function automatic int model_winner();
    int top = 0;
    for (int k = 0; k < 8; k++) if (m_ready[k] && m_prio[k] > top) top = m_prio[k];
`ifdef SCHED_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++)
      if (m_ready[(m_cur + k) % 8] && m_prio[(m_cur + k) % 8] == top) return (m_cur + k) % 8;
`else
    for (int k = 0; k < 8; k++) if (m_ready[k] && m_prio[k] == top) return k;
`endif
    return 0;
  endfunction

  function automatic int model_mask();
    int m = 0;
    for (int k = 0; k < 8; k++) if (m_ready[k]) m |= (1 << k);
    return m;
  endfunction

  // All waiting goes through here so tick counting stays in one process.
  task automatic step();
    @(negedge ACLK);
    if (tick) tick_seen++;
  endtask

  task automatic do_reset();
    ARESETN   = 1'b0;
    cmd_valid = 1'b0;
    sw_ack    = 1'b0;
    repeat (3) step();
    ARESETN = 1'b1;
    model_reset();
  endtask

  task automatic send_cmd(input int op, input int id, input int arg);
    int k = 0;
    cmd_op    = 2'(op);
    cmd_id    = 3'(id);
    cmd_arg   = 16'(arg);
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 10) begin
      step();
      k++;
    end
    check_eq("cmd_ready", 32'(cmd_ready), 1);
    @(posedge ACLK);
    model_apply(op, id, arg);
    #1 cmd_valid = 1'b0;
  endtask

  // Returns at the first negedge with sw_req high; lat counts negedges.
  task automatic wait_req(input int max, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sw_req) begin
        seen = 1'b1;
        lat  = i;
        return;
      end
    end
  endtask

  task automatic do_ack();
    int k = 0;
    sw_ack = 1'b1;
    do begin
      step();
      k++;
    end while (sw_req && k < 20);
    sw_ack = 1'b0;
    check_eq("ack_drop", 32'(sw_req), 0);
  endtask

  int  lat;
  bit  seen;
  int  n_tick, first_tick, period, cnt_a, cnt_b, s0, w;
  int  seq[3];

  initial begin
    ARESETN   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_id    = '0;
    cmd_arg   = '0;
    sw_ack    = 1'b0;

    // Reset state and quiet operation
    do_reset();
    check_eq("rst_cur", 32'(cur_id), 0);
    check_eq("rst_next", 32'(next_id), 0);
    check_eq("rst_mask", 32'(ready_mask), 8'h01);
    check_eq("rst_req", 32'(sw_req), 0);
    check_eq("rst_tick", 32'(tick), 0);
    n_tick = 0; first_tick = -1; period = 0; cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sw_req) cnt_a++;
      if (tick) begin
        if (first_tick < 0) first_tick = i;
        else if (period == 0) period = i - first_tick;
        n_tick++;
      end
    end
    check_eq("idle_req", cnt_a, 0);
    check_eq("tick_period", period, 4);
    check_eq("tick_count", n_tick, 5);
    check_eq("idle_mask", 32'(ready_mask), 8'h01);

    // Priority then ready -> switch to task 3
    send_cmd(3, 3, 5);
    wait_req(6, lat, seen);
    check_eq("prio_only_req", 32'(seen), 0);
    send_cmd(0, 3, 0);
    wait_req(8, lat, seen);
    check_eq("t3_req", 32'(seen), 1);
`ifndef SCHED_ROUND_ROBIN_EN
    check_eq("t3_lat", lat, 3);
`endif
    check_eq("t3_next", 32'(next_id), 3);
    do_ack();
    check_eq("t3_cur", 32'(cur_id), 3);

    // Stray ack while idle does nothing
    sw_ack = 1'b1;
    repeat (3) step();
    sw_ack = 1'b0;
    check_eq("stray_ack_cur", 32'(cur_id), 3);
    check_eq("stray_ack_req", 32'(sw_req), 0);

    // DELAY 2 ticks on the running task
    send_cmd(2, 3, 2);
    s0 = tick_seen;
    wait_req(8, lat, seen);
    check_eq("dly_req0", 32'(seen), 1);
    check_eq("dly_next0", 32'(next_id), 0);
    do_ack();
    check_eq("dly_cur0", 32'(cur_id), 0);
    check_eq("dly_mask", 32'(ready_mask), 8'h01);
    wait_req(30, lat, seen);
    check_eq("wake_req", 32'(seen), 1);
    check_eq("wake_next", 32'(next_id), 3);
    check_eq("wake_ticks", tick_seen - s0 - (tick ? 1 : 0), 2);
    do_ack();
    check_eq("wake_cur", 32'(cur_id), 3);

    // Equal priorities on tasks 2 and 5
    do_reset();
    send_cmd(3, 2, 4);
    repeat (4) step();
    send_cmd(3, 5, 4);
    repeat (4) step();
    send_cmd(0, 2, 0);
    wait_req(8, lat, seen);
    check_eq("tie_req2", 32'(seen), 1);
    check_eq("tie_next2", 32'(next_id), 2);
    do_ack();
    send_cmd(0, 5, 0);
`ifdef SCHED_ROUND_ROBIN_EN
    for (int j = 0; j < 3; j++) begin
      wait_req(20, lat, seen);
      check_eq("rr_req", 32'(seen), 1);
      seq[j] = int'(next_id);
      do_ack();
    end
    check_eq("rr_seq0", seq[0], 5);
    check_eq("rr_seq1", seq[1], 2);
    check_eq("rr_seq2", seq[2], 5);
`else
    wait_req(12, lat, seen);
    check_eq("tie_noreq", 32'(seen), 0);
    check_eq("tie_cur", 32'(cur_id), 2);
    check_eq("tie_next", 32'(next_id), 2);
`endif

    // Delayed ack with a more urgent task arriving meanwhile
    do_reset();
    send_cmd(3, 1, 2);
    repeat (4) step();
    send_cmd(0, 1, 0);
    wait_req(8, lat, seen);
    check_eq("hold_req", 32'(seen), 1);
    send_cmd(3, 6, 7);
    send_cmd(0, 6, 0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (next_id != 3'd1) cnt_a++;
      if (!sw_req) cnt_b++;
    end
    check_eq("hold_next_moved", cnt_a, 0);
    check_eq("hold_req_dropped", cnt_b, 0);
    do_ack();
    check_eq("hold_cur", 32'(cur_id), 1);
    wait_req(10, lat, seen);
    check_eq("urgent_req", 32'(seen), 1);
    check_eq("urgent_next", 32'(next_id), 6);
    do_ack();
    check_eq("urgent_cur", 32'(cur_id), 6);

    // Reset in the middle of a handshake
    do_reset();
    send_cmd(3, 4, 1);
    repeat (4) step();
    send_cmd(0, 4, 0);
    wait_req(8, lat, seen);
    check_eq("mid_req", 32'(seen), 1);
    repeat (2) step();
    #2 ARESETN = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(sw_req), 0);
    check_eq("mid_rst_cur", 32'(cur_id), 0);
    check_eq("mid_rst_next", 32'(next_id), 0);
    repeat (2) step();
    ARESETN = 1'b1;
    model_reset();
    wait_req(20, lat, seen);
    check_eq("post_rst_req", 32'(seen), 0);
    check_eq("post_rst_mask", 32'(ready_mask), 8'h01);

`ifndef SCHED_ROUND_ROBIN_EN
    // Random commands against the model; delays are long enough never to expire
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int op, id, arg;
      op = int'($urandom_range(3, 0));
      id = int'($urandom_range(7, 0));
      if (op == 2) arg = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(1999, 1000));
      else arg = int'($urandom_range(15, 0));
      send_cmd(op, id, arg);
      w = model_winner();
      wait_req(10, lat, seen);
      check_eq("rnd_req", 32'(seen), 32'(w != m_cur));
      if (seen) begin
        check_eq("rnd_lat", lat, 3);
        check_eq("rnd_next", 32'(next_id), w);
        do_ack();
        m_cur = w;
        check_eq("rnd_cur", 32'(cur_id), w);
      end
      check_eq("rnd_mask", 32'(ready_mask), model_mask());
      repeat (2) step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
